// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Constants and types shared by the fetch unit and main_decoder:
//            reset PC, NOP encoding, fetch FSM encoding, major opcodes.
// Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Default reset PC and the canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Wrong-path squash is only reachable once prefetch exists; kept off today
    localparam logic PREFETCH_EN = 1'b0;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetchState_t;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Owns the PC, fetches one instruction at a time over a
//            req/gnt/rvalid interface and hands it to decode over valid/ready.
//            Taken redirects are applied at hand-off; a misaligned target
//            halts fetch until reset.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        misaligned
);

    fetchState_t r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic        r_imemReq, w_imemReq;
    logic        r_instrValid, w_instrValid;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_instrPc, w_instrPc;
    logic [31:0] r_instrPc4, w_instrPc4;
    logic        r_misaligned, w_misaligned;
    logic        r_drop, w_drop;
    logic        r_armed, w_armed;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_targetPc;

    // 32-bit increment, carry out discarded so the PC wraps at 2^32
    assign w_pcPlus4  = r_pc + 32'd4;
    // jalr rule: bit 0 of the target is never kept
    assign w_targetPc = {redirect_target[31:1], 1'b0};

    // Next-state and next-output logic; everything defaults to hold
    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_imemReq    = 1'b0;
        w_instrValid = r_instrValid;
        w_instr      = r_instr;
        w_instrPc    = r_instrPc;
        w_instrPc4   = r_instrPc4;
        w_misaligned = r_misaligned;
        w_drop       = r_drop;
        w_armed      = r_armed;

        case (r_state)
            FETCH_IDLE: begin
                // One quiet cycle after reset; a misaligned halt parks here
                w_armed = 1'b1;
                if (r_armed && !r_misaligned) begin
                    w_state   = FETCH_REQ;
                    w_imemReq = 1'b1;
                end
            end
            FETCH_REQ: begin
                w_imemReq = 1'b1;
                if (imem_gnt) begin
                    w_state   = FETCH_WAIT;
                    w_imemReq = 1'b0;
                    // With prefetch a redirect could race the grant; mark the
                    // returning data as wrong-path in that case
                    w_drop    = r_drop | (PREFETCH_EN & redirect);
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (r_drop) begin
                        w_drop    = 1'b0;
                        w_state   = FETCH_REQ;
                        w_imemReq = 1'b1;
                    end else begin
                        w_state      = FETCH_HOLD;
                        w_instr      = imem_rdata;
                        w_instrPc    = r_pc;
                        w_instrPc4   = w_pcPlus4;
                        w_instrValid = 1'b1;
                    end
                end
            end
            FETCH_HOLD: begin
                if (instr_ready) begin
                    w_instrValid = 1'b0;
                    w_instr      = NOP_INSTR;
                    if (redirect) begin
                        w_pc = w_targetPc;
                        if (redirect_target[1]) begin
                            w_misaligned = 1'b1;
                            w_state      = FETCH_IDLE;
                        end else begin
                            w_state   = FETCH_REQ;
                            w_imemReq = 1'b1;
                        end
                    end else begin
                        w_pc      = w_pcPlus4;
                        w_state   = FETCH_REQ;
                        w_imemReq = 1'b1;
                    end
                end
            end
            default: w_state = FETCH_IDLE;
        endcase
    end

    // State and registered-output update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_PC;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_instrPc    <= RESET_PC;
            r_instrPc4   <= RESET_PC + 32'd4;
            r_misaligned <= 1'b0;
            r_drop       <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_imemReq    <= w_imemReq;
            r_instrValid <= w_instrValid;
            r_instr      <= w_instr;
            r_instrPc    <= w_instrPc;
            r_instrPc4   <= w_instrPc4;
            r_misaligned <= w_misaligned;
            r_drop       <= w_drop;
            r_armed      <= w_armed;
        end
    end

    assign imem_req    = r_imemReq;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instrValid;
    assign instr       = r_instr;
    assign instr_pc    = r_instrPc;
    assign instr_pc4   = r_instrPc4;
    assign misaligned  = r_misaligned;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed vector table plus hand-written sequences for the
//            instruction fetch unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rstN;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic [31:0] ePc4;
        logic        eMis;
    } vec_t;

    vec_t vecs[$];

    instr_fetch_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc4       (instr_pc4),
        .misaligned      (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rstN, input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic ready, input logic redir, input logic [31:0] target);
        reset_n         = rstN;
        imem_gnt        = gnt;
        imem_rvalid     = rv;
        imem_rdata      = rdata;
        instr_ready     = ready;
        redirect        = redir;
        redirect_target = target;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expectOut(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] pc4, input logic mis);
        chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        chk({tag, ".addr"},  imem_addr,            addr);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, valid});
        chk({tag, ".instr"}, instr,                ins);
        chk({tag, ".pc"},    instr_pc,             pc);
        chk({tag, ".pc4"},   instr_pc4,            pc4);
        chk({tag, ".mis"},   {31'd0, misaligned},  {31'd0, mis});
    endtask

    task automatic addv(input logic rstN, input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic ready, input logic redir, input logic [31:0] target,
                        input logic eReq, input logic [31:0] eAddr, input logic eValid,
                        input logic [31:0] eInstr, input logic [31:0] ePc, input logic [31:0] ePc4,
                        input logic eMis);
        vec_t v;
        v.rstN = rstN;  v.gnt = gnt;      v.rv = rv;         v.rdata = rdata;
        v.ready = ready; v.redir = redir; v.target = target;
        v.eReq = eReq;  v.eAddr = eAddr;  v.eValid = eValid; v.eInstr = eInstr;
        v.ePc = ePc;    v.ePc4 = ePc4;    v.eMis = eMis;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        // Reset for two cycles with gnt/rvalid toggling
        addv(0,1,0,32'h0,       0,0,32'h0,  0,32'h00,0,NOP,         32'h00,32'h04,0);
        addv(0,0,1,32'h0,       0,0,32'h0,  0,32'h00,0,NOP,         32'h00,32'h04,0);
        // Release: one quiet IDLE cycle, then request at RESET_PC
        addv(1,1,1,32'h00500093,1,0,32'h0,  0,32'h00,0,NOP,         32'h00,32'h04,0);
        addv(1,1,1,32'h00500093,1,0,32'h0,  1,32'h00,0,NOP,         32'h00,32'h04,0);
        addv(1,1,1,32'h00500093,1,0,32'h0,  0,32'h00,0,NOP,         32'h00,32'h04,0);
        addv(1,1,1,32'h00500093,1,0,32'h0,  0,32'h00,1,32'h00500093,32'h00,32'h04,0);
        // Second sequential instruction, three cycles later
        addv(1,1,1,32'h00a00113,1,0,32'h0,  1,32'h04,0,NOP,         32'h00,32'h04,0);
        addv(1,1,1,32'h00a00113,1,0,32'h0,  0,32'h04,0,NOP,         32'h00,32'h04,0);
        addv(1,1,1,32'h00a00113,1,0,32'h0,  0,32'h04,1,32'h00a00113,32'h04,32'h08,0);
        // Back-pressure for 5 cycles; redirect without ready is ignored
        addv(1,1,1,32'h00a00113,0,1,32'h80, 0,32'h04,1,32'h00a00113,32'h04,32'h08,0);
        for (int i = 0; i < 4; i++)
            addv(1,1,1,32'h00a00113,0,0,32'h0, 0,32'h04,1,32'h00a00113,32'h04,32'h08,0);
        addv(1,1,1,32'h00c00193,1,0,32'h0,  1,32'h08,0,NOP,         32'h04,32'h08,0);
        // Redirects in REQ and WAIT are ignored
        addv(1,1,1,32'h00c00193,1,1,32'h80, 0,32'h08,0,NOP,         32'h04,32'h08,0);
        addv(1,1,1,32'h00c00193,1,1,32'h80, 0,32'h08,1,32'h00c00193,32'h08,32'h0c,0);
        addv(1,1,1,32'h00d00213,1,0,32'h0,  1,32'h0c,0,NOP,         32'h08,32'h0c,0);
        addv(1,1,1,32'h00d00213,1,0,32'h0,  0,32'h0c,0,NOP,         32'h08,32'h0c,0);
        addv(1,1,1,32'h00d00213,1,0,32'h0,  0,32'h0c,1,32'h00d00213,32'h0c,32'h10,0);
        addv(1,1,1,32'h00000463,1,0,32'h0,  1,32'h10,0,NOP,         32'h0c,32'h10,0);
        addv(1,1,1,32'h00000463,1,1,32'h80, 0,32'h10,0,NOP,         32'h0c,32'h10,0);
        addv(1,1,1,32'h00000463,1,0,32'h0,  0,32'h10,1,32'h00000463,32'h10,32'h14,0);
        // Redirect at pc 0x10 to 0x41: bit 0 dropped
        addv(1,1,1,32'h0000006f,1,1,32'h41, 1,32'h40,0,NOP,         32'h10,32'h14,0);
        addv(1,1,1,32'h0000006f,1,0,32'h0,  0,32'h40,0,NOP,         32'h10,32'h14,0);
        addv(1,1,1,32'h0000006f,1,0,32'h0,  0,32'h40,1,32'h0000006f,32'h40,32'h44,0);
        // Misaligned target halts fetch
        addv(1,1,1,32'h0,       1,1,32'h42, 0,32'h42,0,NOP,         32'h40,32'h44,1);
        for (int i = 0; i < 3; i++)
            addv(1,1,1,32'h0,   1,0,32'h0,  0,32'h42,0,NOP,         32'h40,32'h44,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rstN, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                  vecs[i].ready, vecs[i].redir, vecs[i].target);
            step();
            expectOut($sformatf("v%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid,
                      vecs[i].eInstr, vecs[i].ePc, vecs[i].ePc4, vecs[i].eMis);
        end

        // Reset clears sticky misaligned; then reset again mid-WAIT
        drive(0,0,0,32'h0,0,0,32'h0); step();
        expectOut("rst2", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,0,0,32'h0,0,0,32'h0); step();
        expectOut("idle2", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        step();
        expectOut("req2", 1, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        step();  // no grant: request held
        expectOut("nognt", 1, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,1,0,32'h0,0,0,32'h0); step();
        expectOut("wait2", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(0,0,0,32'h0,0,0,32'h0); step();
        expectOut("rstwait", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        // Late response right after release must be discarded
        drive(1,0,1,32'hdeadbeef,0,0,32'h0); step();
        expectOut("lateRsp", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,0,0,32'h0,0,0,32'h0); step();
        expectOut("restart", 1, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,1,0,32'h0,0,0,32'h0); step();
        expectOut("wait3", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,0,0,32'h0,0,0,32'h0); step();  // no rvalid: keep waiting
        expectOut("norv", 0, 32'h0, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,0,1,32'h00100093,0,0,32'h0); step();
        expectOut("hold3", 0, 32'h0, 1, 32'h00100093, 32'h0, 32'h4, 0);

        // PC wrap: redirect to 0xFFFFFFFC, accept, next fetch at 0
        drive(1,0,0,32'h0,1,1,32'hfffffffc); step();
        expectOut("toTop", 1, 32'hfffffffc, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,1,0,32'h0,0,0,32'h0); step();
        expectOut("topWait", 0, 32'hfffffffc, 0, NOP, 32'h0, 32'h4, 0);
        drive(1,0,1,32'h00200113,0,0,32'h0); step();
        expectOut("topHold", 0, 32'hfffffffc, 1, 32'h00200113, 32'hfffffffc, 32'h0, 0);
        drive(1,0,0,32'h0,1,0,32'h0); step();
        expectOut("wrap", 1, 32'h0, 0, NOP, 32'hfffffffc, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream stage of main_decoder. Owns the PC, fetches 32-bit instructions from instruction memory over a request/grant/response handshake, and presents one instruction at a time (with its PC and PC+4) to the decode stage over a valid/ready handshake. Consumes the taken-redirect result produced from the decoder's Branch/Jump/Jalr outputs and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr while not valid (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous, active-low reset
redirect  input  1  taken control transfer (Branch | Jump | Jalr) for the instruction being handed off
redirect_target  input  32  new PC; bit 0 forced to 0 internally (jalr rule)
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (word aligned)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  fetched instruction
instr_valid  output  1  instr/instr_pc/instr_pc4 hold a valid instruction
instr_ready  input  1  decode stage accepts the instruction this cycle
instr  output  32  instruction word to decoder (op = instr[6:0], funct3 = instr[14:12])
instr_pc  output  32  PC of instr
instr_pc4  output  32  instr_pc + 4
misaligned  output  1  sticky: redirect_target[1] was 1

Behaviour:
- Reset (reset_n low at a clk edge): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC, instr_pc4=RESET_PC+4, misaligned=0, drop=0. Reset overrides every other input, including a pending rvalid; a response arriving after reset is ignored (drop cleared, state not WAIT).
- States: IDLE, REQ, WAIT, HOLD. All outputs registered.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr=pc. gnt -> WAIT. No gnt -> stay. Address changes only when redirect is applied.
- WAIT: imem_req=0. rvalid and drop=0 -> HOLD, instr=imem_rdata, instr_pc=pc, instr_pc4=pc+4, instr_valid=1. rvalid and drop=1 -> discard data, clear drop, -> REQ.
- HOLD: instr_valid=1, outputs stable until accepted. instr_ready and no redirect -> pc=pc+4 (mod 2^32 wrap), instr_valid=0, -> REQ. No instr_ready -> stay, nothing changes.
- redirect is sampled only in HOLD with instr_ready=1: pc=redirect_target & ~1, -> REQ, instr_valid=0. redirect_target[1]=1 -> misaligned=1 (sticky until reset), fetch stalls in IDLE-like halt (no further imem_req).
- redirect outside HOLD/ready is ignored.
- Wrong-path: none pre-fetched (single outstanding fetch, no prefetch), so drop only set if reset_n... N/A; drop retained for gnt/redirect in same REQ cycle: redirect in HOLD never overlaps REQ, so drop stays 0 in current scope. It is implemented for future prefetch and must be verified inert.
- Latency: min 3 cycles per instruction (REQ-gnt, WAIT-rvalid, HOLD-ready), one outstanding request max.
- pc+4 arithmetic 32-bit, carry discarded (0xFFFF_FFFC -> 0x0000_0000).

Decomposition:
- Shared package riscv_pkg: RESET_PC, NOP_INSTR, fetch state encoding (2-bit), opcode constants shared with main_decoder.
- No sub-module needed; PC register + incrementer kept inline.

Test Plan:
- Reset with reset_n=0 for 2 cycles, gnt/rvalid toggling -> imem_req=0, instr_valid=0, instr=0x00000013, instr_pc=0; first imem_req with addr 0x0 two cycles after release.
- Sequential: gnt/rvalid immediate, ready=1, rdata 0x00500093,0x00a00113 -> instr_pc 0x0,0x4; instr_pc4 0x4,0x8; one instruction every 3 cycles.
- Back-pressure: ready=0 for 5 cycles in HOLD -> instr, instr_pc stable, no imem_req; ready=1 -> next req addr pc+4.
- Redirect: HOLD at pc 0x10, ready=1, redirect=1, target 0x41 -> next imem_addr 0x40, misaligned=0.
- Misaligned: target 0x42 -> misaligned=1, imem_req stays 0 thereafter until reset.
- Reset mid-WAIT, rvalid arriving one cycle after release -> data discarded, instr_valid=0, fetch restarts at RESET_PC.
